// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: the core has priority, and a dump engine streams a word range out over valid/ready.
// Optional starvation guard (forced grant with core stall) is enabled by defining DUMP_STARVE_GUARD_EN.
module dmem_dump_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_adr,
    input  logic [DATA_W-1:0] core_wd,
    output logic [DATA_W-1:0] core_rd,
    output logic              core_stall,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W:0]   dump_idx,
    output logic              dump_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    localparam int WAIT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
`ifdef DUMP_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W:0]     len_reg;
    logic [ADDR_W:0]     offset_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                busy_reg;
    logic                valid_reg;
    logic                done_reg;
    logic [WAIT_W-1:0]   wait_reg;

    logic                force_grant;
    logic                grant;
    logic [ADDR_W:0]     offset_next;
    logic [ADDR_W-1:0]   dump_adr;
    logic [ADDR_W-1:0]   core_word;
    logic                unused_adr_bits;

    assign core_word       = core_adr[ADDR_W+1:2];
    assign unused_adr_bits = ^{core_adr[31:ADDR_W+2], core_adr[1:0]};
    // Address arithmetic in ADDR_W bits gives the modulo-2^ADDR_W wrap for free.
    assign dump_adr        = base_reg + offset_reg[ADDR_W-1:0];
    assign offset_next     = offset_reg + (ADDR_W+1)'(1);

    assign force_grant = GUARD_ON && (wait_reg >= WAIT_W'(STARVE_LIM));
    assign grant       = (state_reg == FETCH) && (!core_req || force_grant);
    assign core_stall  = (state_reg == FETCH) && core_req && force_grant;

    assign mem_a   = grant ? dump_adr : core_word;
    assign mem_we  = !grant && core_we && !core_stall;
    assign mem_wd  = core_wd;
    assign core_rd = mem_rd;

    assign dump_busy  = busy_reg;
    assign dump_valid = valid_reg;
    assign dump_data  = data_reg;
    assign dump_idx   = offset_reg;
    assign dump_done  = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            len_reg    <= '0;
            offset_reg <= '0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
            wait_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dump_start) begin
                        base_reg   <= dump_base;
                        len_reg    <= dump_len;
                        offset_reg <= '0;
                        wait_reg   <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= (dump_len == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (grant) begin
                        data_reg  <= mem_rd;
                        valid_reg <= 1'b1;
                        wait_reg  <= '0;
                        state_reg <= HOLD;
                    end else if (wait_reg < WAIT_W'(STARVE_LIM)) begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (dump_ready) begin
                        offset_reg <= offset_next;
                        valid_reg  <= 1'b0;
                        if (offset_next == len_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end
                end
                default: begin
                    // Arriving from HOLD the pulse is already up; a zero-length dump raises it one cycle later.
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: a memory model, a beat scoreboard fed at dump start, and a negedge monitor.
module tb_dmem_dump_arbiter;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 8;
    localparam int DEPTH      = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req, core_we;
    logic [31:0]       core_adr;
    logic [DATA_W-1:0] core_wd, core_rd;
    logic              core_stall;
    logic              dump_start;
    logic [ADDR_W-1:0] dump_base;
    logic [ADDR_W:0]   dump_len;
    logic              dump_busy, dump_valid, dump_ready, dump_done;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W:0]   dump_idx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_dump_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wd(core_wd),
        .core_rd(core_rd), .core_stall(core_stall),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_done(dump_done),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory model: words 20..39 hold 0..19, every other word a unique tag; reloaded on reset.
    logic [DATA_W-1:0] tbmem [DEPTH];
    function automatic logic [DATA_W-1:0] init_word(int a);
        return (a >= 20 && a < 40) ? DATA_W'(a - 20) : (32'hA500_0000 | DATA_W'(a));
    endfunction
    assign mem_rd = tbmem[mem_a];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tbmem[i] <= init_word(i);
        end else if (mem_we) begin
            tbmem[mem_a] <= mem_wd;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int idx; logic [DATA_W-1:0] data; int addr; } beat_t;
    beat_t exp_q[$];
    int    hs_cyc_q[$];
    int    done_exp = 0;
    int    done_due = 0;
    int    done_seen = 0;
    int    stall_seen = 0;
    int    last_start = 0;
    int    ready_mode = 1;

    // Reference model: a dump of len words from base yields beat i = mem[(base+i) mod DEPTH].
    task automatic start_dump(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.idx  = i;
            b.addr = (base + i) % DEPTH;
            b.data = tbmem[b.addr];
            exp_q.push_back(b);
        end
        done_exp++;
        if (len == 0) done_due = cyc + 2;
        last_start = cyc;
        $display("start base=%0d len=%0d cycle=%0d", base, len, cyc);
        dump_base  = ADDR_W'(base);
        dump_len   = (ADDR_W+1)'(len);
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_exp != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_timeout", longint'(done_exp != 0), 0);
        chk("idle_after_done", dump_busy, 0);
    endtask

    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       dump_ready = 1'b0;
                1:       dump_ready = 1'b1;
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks port ownership each cycle.
    logic              prev_valid = 1'b0, prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W:0]   prev_idx = '0;
    logic [ADDR_W-1:0] prev_mem_a = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                continue;
            end
            if (core_stall) begin
                stall_seen++;
                chk("stall_store", mem_we, 0);
            end
            if (!core_we) chk("spurious_we", mem_we, 0);
            if (core_req && !core_stall) begin
                chk("core_mem_a", mem_a, core_adr[7:2]);
                chk("core_mem_we", mem_we, core_we);
                chk("core_rd", core_rd, tbmem[core_adr[7:2]]);
            end
            if (dump_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("fetch_addr", prev_mem_a, exp_q[0].addr);
            end
            if (prev_valid && !prev_ready && dump_valid) begin
                chk("hold_data", dump_data, prev_data);
                chk("hold_idx", dump_idx, prev_idx);
            end
            if (dump_valid && dump_ready) begin
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    $display("beat idx=%0d data=%08h exp_idx=%0d exp_data=%08h cycle=%0d",
                             dump_idx, dump_data, b.idx, b.data, cyc);
                    chk("beat_idx", dump_idx, b.idx);
                    chk("beat_data", dump_data, b.data);
                    if (exp_q.size() == 0) done_due = cyc + 1;
                end
            end
            if (dump_done) begin
                done_seen++;
                $display("done cycle=%0d", cyc);
                if (done_exp == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, done_due);
                    chk("done_leftover", exp_q.size(), 0);
                    done_exp--;
                end
            end
            prev_valid = dump_valid;
            prev_ready = dump_ready;
            prev_data  = dump_data;
            prev_idx   = dump_idx;
            prev_mem_a = mem_a;
        end
    end

    initial begin
        int n;
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_adr = '0; core_wd = '0;
        dump_start = 1'b0; dump_base = '0; dump_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", dump_busy, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_data", dump_data, 0);
        chk("rst_idx", dump_idx, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Base dump with idle core: one beat every two cycles.
        hs_cyc_q.delete();
        start_dump(20, 20);
        wait_done(200);
        chk("t1_beats", hs_cyc_q.size(), 20);
        if (hs_cyc_q.size() == 20) begin
            chk("t1_first", hs_cyc_q[0], last_start + 2);
            chk("t1_rate", hs_cyc_q[19] - hs_cyc_q[0], 38);
        end

        // Backpressure held on the third beat.
        start_dump(20, 8);
        n = 0;
        while (!(dump_valid && dump_idx == 2) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("t2_reach_beat3", longint'(n < 50), 1);
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1 ready_mode = 1;
        wait_done(100);

        // Zero length, then address wrap.
        start_dump(5, 0);
        wait_done(10);
        start_dump(62, 4);
        wait_done(50);

        // Core contention with toggling stores to words 40..59.
        stall_seen = 0;
        hs_cyc_q.delete();
        core_req = 1'b1;
        start_dump(0, 3);
`ifdef DUMP_STARVE_GUARD_EN
        n = 0;
        while (done_exp != 0 && n < 200) begin
            core_we  = ~core_we;
            core_adr = 32'($urandom_range(40, 59)) << 2;
            core_wd  = $urandom;
            @(posedge clk); #1; n++;
        end
        chk("t5_stalls", stall_seen, 3);
        if (hs_cyc_q.size() > 0) chk("t5_first", hs_cyc_q[0], last_start + STARVE_LIM + 2);
`else
        for (int i = 0; i < 30; i++) begin
            core_we  = ~core_we;
            core_adr = 32'($urandom_range(40, 59)) << 2;
            core_wd  = $urandom;
            @(posedge clk); #1;
            chk("t5_no_valid", dump_valid, 0);
        end
        chk("t5_no_stall", stall_seen, 0);
`endif
        core_req = 1'b0; core_we = 1'b0;
        wait_done(50);

        // Reset during HOLD of beat 5 aborts without a done pulse.
        start_dump(20, 10);
        n = 0;
        while (!(dump_valid && dump_idx == 4) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("t6_reach_beat5", longint'(n < 50), 1);
        ready_mode = 0;
        @(posedge clk); #1;
        exp_q.delete();
        done_exp = 0;
        n = done_seen;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", dump_busy, 0);
        chk("t6_valid", dump_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_done", done_seen - n, 0);
        ready_mode = 1;
        start_dump(20, 10);
        wait_done(100);

        // Random dumps with random backpressure and core reads.
        ready_mode = 2;
        for (int d = 0; d < 6; d++) begin
            int cnt;
            start_dump(int'($urandom_range(0, 63)), int'($urandom_range(0, 12)));
            cnt = 0;
            while (done_exp != 0 && cnt < 400) begin
                core_req = 1'($urandom_range(0, 1));
                core_adr = 32'($urandom_range(0, 63)) << 2;
                @(posedge clk); #1; cnt++;
            end
            core_req = 1'b0;
            wait_done(20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
